// File: rtl/img_byte_buffer.sv
// Packs host-link bytes into one IMG_BITS image word and holds it until the controller clears it.
// img_buffer_full rises 1 cycle after the last accept; rx_ready is low while full or while buf_clear is high.
module img_byte_buffer #(
    parameter int IMG_BITS = 904,
    parameter int BYTE_W   = 8,
    localparam int NUM_BEATS = IMG_BITS / BYTE_W,
    localparam int CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                buf_clear,
    output logic [IMG_BITS-1:0] img_out,
    output logic                img_buffer_full,
    output logic [CNT_W-1:0]    beat_count,
    output logic                overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    logic   accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        rx_ready = 1'b0;
        accept   = 1'b0;

        // buf_clear blocks the handshake so a beat offered alongside it is never half-taken.
        if (state != FULL) begin
            rx_ready = !buf_clear;
        end
        accept = rx_valid && rx_ready;

        if (buf_clear) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = (NUM_BEATS == 1) ? FULL : FILL;
                    end
                end
                FILL: begin
                    if (accept && (beat_count == CNT_W'(NUM_BEATS - 1))) begin
                        state_n = FULL;
                    end
                end
                FULL: begin
                    state_n = FULL;
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    // First beat ends up in the MSBs after NUM_BEATS left shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_out <= '0;
        end else if (accept) begin
            img_out <= {img_out[IMG_BITS-BYTE_W-1:0], rx_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (buf_clear) begin
            beat_count <= '0;
        end else if (accept) begin
            beat_count <= beat_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_buffer_full <= 1'b0;
        end else begin
            img_buffer_full <= (state_n == FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (buf_clear) begin
            overflow <= 1'b0;
        end else if ((state == FULL) && rx_valid) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_img_byte_buffer.sv
// Bench for img_byte_buffer: directed frames with a reference image queue checked on each full rise.
module tb_img_byte_buffer;

    localparam int IMG_BITS  = 904;
    localparam int BYTE_W    = 8;
    localparam int NUM_BEATS = IMG_BITS / BYTE_W;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [BYTE_W-1:0]   rx_data = '0;
    logic                rx_valid = 1'b0;
    logic                rx_ready;
    logic                buf_clear = 1'b0;
    logic [IMG_BITS-1:0] img_out;
    logic                img_buffer_full;
    logic [CNT_W-1:0]    beat_count;
    logic                overflow;

    img_byte_buffer #(.IMG_BITS(IMG_BITS), .BYTE_W(BYTE_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .buf_clear       (buf_clear),
        .img_out         (img_out),
        .img_buffer_full (img_buffer_full),
        .beat_count      (beat_count),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int pushes   = 0;

    logic [IMG_BITS-1:0] exp_q[$];
    logic [IMG_BITS-1:0] model_img = '0;
    int                  model_cnt = 0;
    logic [IMG_BITS-1:0] held_img;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_img(input string name, input logic [IMG_BITS-1:0] act,
                             input logic [IMG_BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < NUM_BEATS; i++) begin
                if (act[IMG_BITS-1-i*BYTE_W -: BYTE_W] !== exp[IMG_BITS-1-i*BYTE_W -: BYTE_W]) begin
                    $display("FAIL %s first bad beat=%0d actual=%0h expected=%0h", name, i,
                             act[IMG_BITS-1-i*BYTE_W -: BYTE_W], exp[IMG_BITS-1-i*BYTE_W -: BYTE_W]);
                    break;
                end
            end
        end
    endtask

    // Called at a negedge; offers one beat for one cycle and updates the reference image.
    task automatic send(input logic [BYTE_W-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        if (model_cnt < NUM_BEATS) begin
            model_img = {model_img[IMG_BITS-BYTE_W-1:0], d};
            model_cnt++;
            if (model_cnt == NUM_BEATS) begin
                exp_q.push_back(model_img);
                pushes++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_buf();
        buf_clear = 1'b1;
        @(posedge clk);
        model_cnt = 0;
        @(negedge clk);
        buf_clear = 1'b0;
    endtask

    // Monitor: every rising edge of img_buffer_full must present the next expected frame.
    initial begin
        logic                prev_full;
        logic [IMG_BITS-1:0] exp_img;
        prev_full = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_full = 1'b0;
            end else begin
                if (img_buffer_full && !prev_full) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected_full actual=1 expected=0");
                    end else begin
                        exp_img = exp_q.pop_front();
                        check_img("mon_img", img_out, exp_img);
                        check("mon_count", 32'(beat_count), NUM_BEATS);
                    end
                end
                prev_full = img_buffer_full;
            end
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_ready", 32'(rx_ready), 1);
        check("rst_full", 32'(img_buffer_full), 0);
        check("rst_count", 32'(beat_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check_img("rst_img", img_out, '0);
        @(negedge clk);
        rst = 1'b0;

        // T1: 113 beats 0x00..0x70 back-to-back
        for (int i = 0; i < NUM_BEATS - 1; i++) send(8'(i));
        check("t1_full_before_last", 32'(img_buffer_full), 0);
        check("t1_count_112", 32'(beat_count), 112);
        send(8'(NUM_BEATS - 1));
        check("t1_full", 32'(img_buffer_full), 1);
        check("t1_msb", 32'(img_out[903:896]), 8'h00);
        check("t1_lsb", 32'(img_out[7:0]), 8'h70);
        check("t1_count", 32'(beat_count), 113);
        check("t1_ready_full", 32'(rx_ready), 0);
        clear_buf();
        check("t1_clear_full", 32'(img_buffer_full), 0);

        // T2: 112 beats, a 20-cycle gap, then the last beat
        for (int i = 0; i < NUM_BEATS - 1; i++) send(8'(i * 3 + 1));
        idle(20);
        check("t2_full_gap", 32'(img_buffer_full), 0);
        check("t2_count_gap", 32'(beat_count), 112);
        check("t2_ready_gap", 32'(rx_ready), 1);
        send(8'hC3);
        check("t2_full", 32'(img_buffer_full), 1);

        // T3: extra beats while full are dropped and flag overflow
        held_img = img_out;
        check("t3_ovf_before", 32'(overflow), 0);
        for (int i = 0; i < 3; i++) begin
            rx_data  = 8'hF0 + 8'(i);
            rx_valid = 1'b1;
            #1;
            check("t3_ready", 32'(rx_ready), 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check_img("t3_img_held", img_out, held_img);
        check("t3_ovf", 32'(overflow), 1);
        check("t3_count", 32'(beat_count), 113);
        clear_buf();
        check("t3_clr_full", 32'(img_buffer_full), 0);
        check("t3_clr_ovf", 32'(overflow), 0);
        check("t3_clr_count", 32'(beat_count), 0);
        check_img("t3_clr_img_kept", img_out, held_img);

        // T4: buf_clear together with rx_valid mid-frame
        for (int i = 0; i < 50; i++) send(8'(i + 8'h40));
        check("t4_count50", 32'(beat_count), 50);
        rx_data   = 8'h77;
        rx_valid  = 1'b1;
        buf_clear = 1'b1;
        #1;
        check("t4_ready_clr", 32'(rx_ready), 0);
        @(negedge clk);
        rx_valid  = 1'b0;
        buf_clear = 1'b0;
        model_cnt = 0;
        check("t4_count_clr", 32'(beat_count), 0);
        check_img("t4_beat_dropped", img_out, model_img);
        for (int i = 0; i < NUM_BEATS; i++) send(8'hA5);
        check("t4_full", 32'(img_buffer_full), 1);
        check_img("t4_all_a5", img_out, {NUM_BEATS{8'hA5}});
        clear_buf();

        // T5: asynchronous reset mid-cycle while beat 60 is offered
        for (int i = 0; i < 59; i++) send(8'(i ^ 8'h5A));
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        #2;
        rst      = 1'b1;
        rx_valid = 1'b0;
        #1;
        check("t5_count", 32'(beat_count), 0);
        check("t5_full", 32'(img_buffer_full), 0);
        check("t5_ovf", 32'(overflow), 0);
        check("t5_ready", 32'(rx_ready), 1);
        check_img("t5_img", img_out, '0);
        #1 rst = 1'b0;
        model_img = '0;
        model_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < NUM_BEATS; i++) send(8'(255 - i));
        check("t5_full_after", 32'(img_buffer_full), 1);
        clear_buf();

        // T6: ten frames of random data with random valid gaps
        for (int f = 0; f < 10; f++) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom));
            end
            idle(2);
            check("t6_full_held", 32'(img_buffer_full), 1);
            clear_buf();
            check("t6_full_clr", 32'(img_buffer_full), 0);
        end

        idle(3);
        check("end_pulses", 32'(pulses), 32'(pushes));
        check("end_queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
